text_video_scanout: RTL and testbench
=====================================

# text_video_scanout

Text-mode display stage fed by the memory controller's video RAM write port. It holds an 80x25 cell buffer of 16-bit character/attribute words and accepts word writes from the controller. It generates 640x480@60 VGA timing and scans the buffer through an external 8x16 font ROM, producing a 4-bit colour index per pixel plus sync signals for the DAC/pin stage.

## Interface
Parameters:
- COLS, 80: text columns; cell width 8 px.
- ROWS, 25: text rows; cell height 16 px.

Ports:
- clk  in  1  single clock, 25 MHz pixel clock.
- rst  in  1  asynchronous, active-high reset.
- video_ram_addr  in  12  cell index written by memory controller, row-major (row*COLS+col).
- video_ram_data  in  16  [7:0] character code, [11:8] foreground index, [15:12] background index.
- video_ram_we  in  1  write strobe, one write per cycle it is high.
- font_addr  out  12  {char[7:0], glyph_row[3:0]}.
- font_data  in  8  glyph row, valid one cycle after font_addr; bit 7 = leftmost pixel.
- pix_color  out  4  colour index.
- pix_active  out  1  pixel in 640x480 visible region.
- hsync_n  out  1  horizontal sync, active low.
- vsync_n  out  1  vertical sync, active low.
- frame_start  out  1  one-cycle pulse with pixel (0,0) on outputs.

## Operation
- Cell RAM: COLS*ROWS x 16, one write port, one synchronous read port (read-first). Power-up contents zero via initialisation; rst does not clear it.
- Write: on clk with video_ram_we=1 and addr < COLS*ROWS, store data. addr >= 2000 ignored; no aliasing.
- Counters: hcnt 0..799, vcnt 0..524; hcnt wraps 799->0 and increments vcnt; vcnt wraps 524->0 with hcnt.
- Horizontal: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
- Vertical: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
- Pipeline per pixel:
  - S0: cell addr = (vcnt>>4)*COLS + (hcnt>>3), drives RAM read.
  - S1: RAM word valid; font_addr = {char, vcnt[3:0]} registered.
  - S2: font_data valid; select bit 7-hcnt[2:0], delayed to match; fg if 1, bg if 0.
  - S3: output registers.
- Multiply by 80 implemented as (row<<6)+(row<<4); 12-bit result.
- Text area = visible pixels with vcnt<400. Visible rows 400-479: pix_active=1, pix_color=0, no font use. Blanking: pix_active=0, pix_color=0.
- font_addr outside text area don't-care; bench must not check it there.

## Timing
- Reset values: pix_color=0, pix_active=0, hsync_n=1, vsync_n=1, frame_start=0, font_addr=0, hcnt=vcnt=0, pipeline cleared. Outputs change asynchronously on rst assertion.
- First clk edge after rst deasserts evaluates hcnt=0,vcnt=0; counter values appear on outputs 3 cycles later. Fixed latency 3 for colour, active, syncs, frame_start; all aligned.
- hsync_n low for 96 cycles every 800; vsync_n low for 1600 cycles every 420000.
- RAM write to cell being read same cycle: display shows old word that pixel, new word from next read.
- Write latency to display: visible from next scan of that cell; no tearing protection.
- Reset mid-frame: counters restart at (0,0); RAM contents preserved; no spurious frame_start during reset.

## Test plan
- Reset/hsync: rst high 5 cycles, release -> outputs at reset values during rst; hsync_n falls at cycle 659 after release, stays low 96 cycles, period 800.
- Vsync/frame: run 2 frames -> vsync_n low 1600 cycles starting line 490 (+3 cycles); frame_start pulses every 420000 cycles, coincident with pix_active rising at (0,0).
- Glyph render: write 0x0748 to addr 0; font model returns 0x80 for font_addr 0x480 -> font_addr=0x480 seen; pixel (0,0) colour 7, pixels 1-7 colour 0.
- Address bounds: write 0xF141 to 1999, 0x1234 to 2000 -> cell col 79 row 24 uses char 0x41 fg 1 bg F; cell 0 unchanged.
- Border/blank: pixels in rows 400-479 -> pix_active=1, colour 0; hcnt 640-799 -> pix_active=0, colour 0.
- Async reset mid-frame: assert rst at line 200 pixel 300 -> outputs reset immediately without clk; after release timing restarts at (0,0); previously written cells still render.

Source files
------------

// File: rtl/text_video_scanout.sv
// Text-mode scanout: 80x25 cell buffer, 640x480@60 timing, external 8x16 font ROM.
// Four-stage pixel pipeline (S0 address, S1 RAM word, S2 glyph row, S3 outputs).
module text_video_scanout #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] video_ram_addr,
    input  logic [15:0] video_ram_data,
    input  logic        video_ram_we,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [3:0]  pix_color,
    output logic        pix_active,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        frame_start
);

    localparam int unsigned CELLS      = COLS * ROWS;
    localparam logic [11:0] CELL_LIMIT = 12'(CELLS);
    localparam logic [9:0]  TEXT_LINES = 10'(ROWS * 16);
    localparam logic [9:0]  H_VIS      = 10'd640;
    localparam logic [9:0]  H_SYNC_BEG = 10'd656;
    localparam logic [9:0]  H_SYNC_END = 10'd752;
    localparam logic [9:0]  H_LAST     = 10'd799;
    localparam logic [9:0]  V_VIS      = 10'd480;
    localparam logic [9:0]  V_SYNC_BEG = 10'd490;
    localparam logic [9:0]  V_SYNC_END = 10'd492;
    localparam logic [9:0]  V_LAST     = 10'd524;

    // Cell buffer powers up cleared; rst deliberately leaves it alone.
    logic [15:0] cell_ram [CELLS] = '{default: 16'h0000};

    logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [5:0]  cell_row;
    logic [6:0]  cell_col;
    logic [11:0] row_base, cell_addr;
    logic        s0_active, s0_text, s0_hs, s0_vs, s0_fs;

    logic [15:0] ram_rdata_q, ram_rdata_d;
    logic        s1_active_q, s1_text_q, s1_hs_q, s1_vs_q, s1_fs_q;
    logic [2:0]  s1_px_q;
    logic [3:0]  s1_line_q;

    logic        s2_active_q, s2_text_q, s2_hs_q, s2_vs_q, s2_fs_q;
    logic [2:0]  s2_px_q;
    logic [3:0]  s2_fg_q, s2_bg_q;
    logic [11:0] font_addr_q, font_addr_d;

    logic [3:0]  pix_color_q, pix_color_d;
    logic        pix_active_q, hsync_n_q, vsync_n_q, frame_start_q;

    // Write port; addresses past the last cell are dropped, not wrapped.
    always_ff @(posedge clk) begin
        if (video_ram_we && (video_ram_addr < CELL_LIMIT)) begin
            cell_ram[video_ram_addr] <= video_ram_data;
        end
    end

    // Counter next-state and S0 decode of the current scan position.
    always_comb begin
        hcnt_d = (hcnt_q == H_LAST) ? 10'd0 : hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
        end
        cell_row = vcnt_q[9:4];
        cell_col = hcnt_q[9:3];
        if (COLS == 80) begin
            row_base = ({6'd0, cell_row} << 6) + ({6'd0, cell_row} << 4);
        end else begin
            row_base = 12'(cell_row * COLS);
        end
        cell_addr = row_base + {5'd0, cell_col};
        s0_active = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
        s0_text   = s0_active && (vcnt_q < TEXT_LINES);
        s0_hs     = !((hcnt_q >= H_SYNC_BEG) && (hcnt_q < H_SYNC_END));
        s0_vs     = !((vcnt_q >= V_SYNC_BEG) && (vcnt_q < V_SYNC_END));
        s0_fs     = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
        // Read-first: the write port updates with NBA, so this sees the old word.
        ram_rdata_d = s0_text ? cell_ram[cell_addr] : 16'h0000;
    end

    // S1 font address and S3 colour selection from the glyph row.
    always_comb begin
        font_addr_d = {ram_rdata_q[7:0], s1_line_q};
        pix_color_d = 4'h0;
        if (s2_text_q) begin
            pix_color_d = font_data[~s2_px_q] ? s2_fg_q : s2_bg_q;
        end
    end

    // Counters and all pipeline stages; sync flags reset to their idle (high) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            ram_rdata_q   <= '0;
            s1_active_q   <= 1'b0;
            s1_text_q     <= 1'b0;
            s1_hs_q       <= 1'b1;
            s1_vs_q       <= 1'b1;
            s1_fs_q       <= 1'b0;
            s1_px_q       <= '0;
            s1_line_q     <= '0;
            s2_active_q   <= 1'b0;
            s2_text_q     <= 1'b0;
            s2_hs_q       <= 1'b1;
            s2_vs_q       <= 1'b1;
            s2_fs_q       <= 1'b0;
            s2_px_q       <= '0;
            s2_fg_q       <= '0;
            s2_bg_q       <= '0;
            font_addr_q   <= '0;
            pix_color_q   <= '0;
            pix_active_q  <= 1'b0;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            ram_rdata_q   <= ram_rdata_d;
            s1_active_q   <= s0_active;
            s1_text_q     <= s0_text;
            s1_hs_q       <= s0_hs;
            s1_vs_q       <= s0_vs;
            s1_fs_q       <= s0_fs;
            s1_px_q       <= hcnt_q[2:0];
            s1_line_q     <= vcnt_q[3:0];
            s2_active_q   <= s1_active_q;
            s2_text_q     <= s1_text_q;
            s2_hs_q       <= s1_hs_q;
            s2_vs_q       <= s1_vs_q;
            s2_fs_q       <= s1_fs_q;
            s2_px_q       <= s1_px_q;
            s2_fg_q       <= ram_rdata_q[11:8];
            s2_bg_q       <= ram_rdata_q[15:12];
            font_addr_q   <= font_addr_d;
            pix_color_q   <= pix_color_d;
            pix_active_q  <= s2_active_q;
            hsync_n_q     <= s2_hs_q;
            vsync_n_q     <= s2_vs_q;
            frame_start_q <= s2_fs_q;
        end
    end

    assign font_addr   = font_addr_q;
    assign pix_color   = pix_color_q;
    assign pix_active  = pix_active_q;
    assign hsync_n     = hsync_n_q;
    assign vsync_n     = vsync_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_text_video_scanout.sv
// Scoreboard bench for text_video_scanout: a timing/font model pushes the expected
// outputs per evaluated pixel; they are popped when the pipeline delivers them.
module tb_text_video_scanout;

    localparam int H_TOTAL = 800;
    localparam int FRAME   = 420000;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] video_ram_addr;
    logic [15:0] video_ram_data;
    logic        video_ram_we;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic [3:0]  pix_color;
    logic        pix_active, hsync_n, vsync_n, frame_start;

    text_video_scanout #(.COLS(80), .ROWS(25)) dut (
        .clk            (clk),
        .rst            (rst),
        .video_ram_addr (video_ram_addr),
        .video_ram_data (video_ram_data),
        .video_ram_we   (video_ram_we),
        .font_addr      (font_addr),
        .font_data      (font_data),
        .pix_color      (pix_color),
        .pix_active     (pix_active),
        .hsync_n        (hsync_n),
        .vsync_n        (vsync_n),
        .frame_start    (frame_start)
    );

    always #20 clk = ~clk;

    // Font ROM model: fixed glyph row for 'H' row 0, arbitrary pattern elsewhere.
    function automatic logic [7:0] font_rom(input logic [11:0] a);
        if (a == 12'h480) return 8'h80;
        return a[11:4] ^ {a[3:0], ~a[3:0]};
    endfunction

    assign font_data = font_rom(font_addr);

    logic [15:0] shadow [2000];
    logic [7:0]  exp_q [$];
    logic [12:0] fa_q [$];
    int n_checks = 0;
    int n_errors = 0;
    int mh, mv, stp;
    bit phase1;
    int hs_low, vs_low, fs_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (step %0d)", tag, got, exp, stp);
        end
    endtask

    function automatic logic [7:0] expect_pix(input int h, input int v);
        logic [15:0] w;
        logic [7:0]  g;
        logic [3:0]  c;
        logic        act;
        act = (h < 640) && (v < 480);
        c = 4'h0;
        if (act && v < 400) begin
            w = shadow[(v / 16) * 80 + h / 8];
            g = font_rom({w[7:0], 4'(v % 16)});
            c = g[7 - (h % 8)] ? w[11:8] : w[15:12];
        end
        return {c, act, !(h >= 656 && h < 752), !(v >= 490 && v < 492), (h == 0 && v == 0)};
    endfunction

    function automatic logic [12:0] expect_fa(input int h, input int v);
        logic [15:0] w;
        if (!(h < 640 && v < 400)) return 13'h0;
        w = shadow[(v / 16) * 80 + h / 8];
        return {1'b1, w[7:0], 4'(v % 16)};
    endfunction

    function automatic logic [7:0] outs();
        return {pix_color, pix_active, hsync_n, vsync_n, frame_start};
    endfunction

    task automatic sb_restart();
        exp_q.delete();
        fa_q.delete();
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h06);
        fa_q.push_back({1'b1, 12'h000});
        mh  = 0;
        mv  = 0;
        stp = 0;
    endtask

    // One pixel clock: predict from the model (read-first), then compare the outputs.
    task automatic step();
        logic [7:0]  e;
        logic [12:0] f;
        int          pix_idx;
        @(posedge clk);
        exp_q.push_back(expect_pix(mh, mv));
        fa_q.push_back(expect_fa(mh, mv));
        if (video_ram_we && video_ram_addr < 12'd2000) shadow[video_ram_addr] = video_ram_data;
        mh = mh + 1;
        if (mh == H_TOTAL) begin
            mh = 0;
            mv = (mv == 524) ? 0 : mv + 1;
        end
        stp++;
        #1;
        e = exp_q.pop_front();
        check("pixel_outputs", outs(), e);
        f = fa_q.pop_front();
        if (f[12]) check("font_addr", font_addr, f[11:0]);
        pix_idx = stp - 3;
        if (phase1 && pix_idx >= 0 && pix_idx < FRAME) begin
            if (!hsync_n) hs_low++;
            if (!vsync_n) vs_low++;
            if (frame_start) fs_cnt++;
        end
        // Directed points with hand-derived values.
        if (stp == 2) check("glyph_font_addr", font_addr, 12'h480);
        if (stp == 3) check("pixel00_colour", pix_color, 4'h7);
        if (stp == 3) check("pixel00_fs_active", {frame_start, pix_active}, 2'b11);
        if (stp >= 4 && stp <= 10) check("pixel1to7_colour", pix_color, 4'h0);
        if (stp == 643) check("hblank_pixel", {pix_active, pix_color}, 5'b00000);
        if (stp == 658) check("hsync_before_fall", hsync_n, 1'b1);
        if (stp == 659) check("hsync_fall", hsync_n, 1'b0);
        if (stp == 755) check("hsync_rise", hsync_n, 1'b1);
        if (stp == 307834) check("cell1999_font_addr", font_addr, 12'h410);
        if (stp == 307835) check("cell1999_bg", pix_color, 4'hF);
        if (stp == 307836) check("cell1999_fg", pix_color, 4'h1);
        if (stp == 320003) check("border_row400", {pix_active, pix_color}, 5'b10000);
        if (stp == 392002) check("vsync_before_fall", vsync_n, 1'b1);
        if (stp == 392003) check("vsync_fall", vsync_n, 1'b0);
        if (stp == 393603) check("vsync_rise", vsync_n, 1'b1);
        if (stp == 420003) check("frame_start_period", {frame_start, pix_active}, 2'b11);
    endtask

    task automatic ram_write(input logic [11:0] a, input logic [15:0] d);
        video_ram_we   = 1'b1;
        video_ram_addr = a;
        video_ram_data = d;
    endtask

    initial begin
        for (int i = 0; i < 2000; i++) shadow[i] = 16'h0000;
        rst            = 1'b1;
        video_ram_we   = 1'b0;
        video_ram_addr = '0;
        video_ram_data = '0;
        phase1         = 1'b1;
        hs_low         = 0;
        vs_low         = 0;
        fs_cnt         = 0;
        stp            = 0;
        #1;
        check("reset_outputs_t0", outs(), 8'h06);

        // Hold reset for 5 cycles, loading cell 0 with 'H' fg 7 bg 0 meanwhile.
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            if (video_ram_we && video_ram_addr < 12'd2000) shadow[video_ram_addr] = video_ram_data;
            #1;
            check("reset_outputs", outs(), 8'h06);
            check("reset_font_addr", font_addr, 12'h000);
            if (c == 0) ram_write(12'd0, 16'h0748);
            else video_ram_we = 1'b0;
        end
        rst = 1'b0;
        sb_restart();

        // Frame 0 and into frame 1 up to line 200 pixel 300.
        while (stp < FRAME + 200 * H_TOTAL + 300) begin
            step();
            if (stp == 8) ram_write(12'd1, 16'h2AFF);      // collides with read of cell 1
            if (stp == 9) ram_write(12'd1999, 16'hF141);
            if (stp == 10) ram_write(12'd2000, 16'h1234);  // out of range, must not alias
            if (stp == 11) video_ram_we = 1'b0;
            if (stp == FRAME + 3) begin
                phase1 = 1'b0;
                check("hsync_low_cycles", hs_low, 50400);
                check("vsync_low_cycles", vs_low, 1600);
                check("frame_start_pulses", fs_cnt, 1);
            end
        end

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", outs(), 8'h06);
        check("async_reset_font_addr", font_addr, 12'h000);
        @(posedge clk);
        #1;
        check("held_reset_outputs", outs(), 8'h06);
        rst = 1'b0;
        sb_restart();
        for (int i = 0; i < 2 * H_TOTAL + 20; i++) step();
        check("scoreboard_depth", exp_q.size(), 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
